piezo_melody_seq: RTL and testbench

//  Parametrised alarm-melody sequencer driving a differential piezo directly.
//  - Plays NUM_NOTES notes from a parameter table, then a pause, then loops or stops.
//  - Contains its own frequency, duration and 10 ms tick counters, so no external note_over/clr.
//  - Sits between the alarm control logic (start/stop) and the piezo pins.

---
 rtl/piezo_melody_seq.sv | 185 ++++++++++++++++++
 tb/tb_piezo_melody_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/piezo_melody_seq.sv
// Alarm-melody sequencer: plays a parameter table of notes on a differential piezo,
// then pauses, then loops or stops. Tone, duration and tick timing are all internal.
module piezo_melody_seq #(
  parameter int                         NUM_NOTES = 3,
  parameter int                         PER_W     = 15,
  parameter int                         DUR_W     = 8,
  parameter int                         TICK_DIV  = 500000,
  parameter logic [NUM_NOTES*PER_W-1:0] NOTE_PER  = {15'd18961, 15'd23889, 15'd31888},
  parameter logic [NUM_NOTES*DUR_W-1:0] NOTE_DUR  = {8'd34, 8'd17, 8'd17},
  parameter logic [DUR_W-1:0]           PAUSE_DUR = 8'd100,
  localparam int                        IW        = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  output logic          piezo,
  output logic          piezo_n,
  output logic          busy,
  output logic [IW-1:0] note_idx,
  output logic [2:0]    state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] PAUSE_LIM = (PAUSE_DUR == '0) ? '0 : PAUSE_DUR - DUR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_PLAY  = 3'b010,
    ST_PAUSE = 3'b100
  } state_e;

  function automatic logic [PER_W-1:0] note_per(input logic [IW-1:0] idx);
    logic [PER_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      p = (idx == IW'(i)) ? NOTE_PER[i*PER_W +: PER_W] : p;
    end
    return p;
  endfunction

  // Last duration-tick index of a note; a zero duration is played as one tick.
  function automatic logic [DUR_W-1:0] note_dur_lim(input logic [IW-1:0] idx);
    logic [DUR_W-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      d = (idx == IW'(i)) ? NOTE_DUR[i*DUR_W +: DUR_W] : d;
    end
    return (d == '0) ? '0 : d - DUR_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [IW-1:0]    note_idx_q, note_idx_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [PER_W-1:0] freq_q, freq_d;
  logic             piezo_q, piezo_d;
  logic             piezo_n_q, piezo_n_d;
  logic             busy_q, busy_d;

  logic [PER_W-1:0] cur_per;
  logic [PER_W-1:0] nxt_per;
  logic             tick_last;
  logic             tone_on;

  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
    tick_d     = tick_q;
    dur_d      = dur_q;
    freq_d     = freq_q;
    cur_per    = note_per(note_idx_q);
    tick_last  = (tick_q == TICK_LAST);

    if (stop) begin
      state_d    = ST_IDLE;
      note_idx_d = '0;
      tick_d     = '0;
      dur_d      = '0;
      freq_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          note_idx_d = '0;
          tick_d     = '0;
          dur_d      = '0;
          freq_d     = '0;
          if (start) begin
            state_d = ST_PLAY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (tick_last && (dur_q == note_dur_lim(note_idx_q))) begin
            tick_d = '0;
            dur_d  = '0;
            freq_d = '0;
            if (note_idx_q == IW'(NUM_NOTES - 1)) begin
              state_d = ST_PAUSE;
            end else begin
              note_idx_d = note_idx_q + IW'(1);
            end
          end else begin
            if (tick_last) begin
              tick_d = '0;
              dur_d  = dur_q + DUR_W'(1);
            end else begin
              tick_d = tick_q + TW'(1);
            end
            // Periods below 2 are rests; keep the tone counter parked at zero.
            if ((cur_per < PER_W'(2)) || (freq_q == cur_per - PER_W'(1))) begin
              freq_d = '0;
            end else begin
              freq_d = freq_q + PER_W'(1);
            end
          end
        end
        ST_PAUSE: begin
          freq_d = '0;
          if (tick_last && (dur_q == PAUSE_LIM)) begin
            tick_d     = '0;
            dur_d      = '0;
            note_idx_d = '0;
            if (loop_en) begin
              state_d = ST_PLAY;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (tick_last) begin
            tick_d = '0;
            dur_d  = dur_q + DUR_W'(1);
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: begin
          state_d    = ST_IDLE;
          note_idx_d = '0;
          tick_d     = '0;
          dur_d      = '0;
          freq_d     = '0;
        end
      endcase
    end

    // Drive levels are computed from next-state values so the pins come straight from flops.
    nxt_per   = note_per(note_idx_d);
    tone_on   = (state_d == ST_PLAY) && (nxt_per >= PER_W'(2));
    piezo_d   = tone_on && (freq_d < (nxt_per >> 1));
    piezo_n_d = tone_on && !(freq_d < (nxt_per >> 1));
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      note_idx_q <= '0;
      tick_q     <= '0;
      dur_q      <= '0;
      freq_q     <= '0;
      piezo_q    <= 1'b0;
      piezo_n_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
      tick_q     <= tick_d;
      dur_q      <= dur_d;
      freq_q     <= freq_d;
      piezo_q    <= piezo_d;
      piezo_n_q  <= piezo_n_d;
      busy_q     <= busy_d;
    end
  end

  assign piezo    = piezo_q;
  assign piezo_n  = piezo_n_q;
  assign busy     = busy_q;
  assign note_idx = note_idx_q;
  assign state    = state_q;

endmodule

// File: tb/tb_piezo_melody_seq.sv
// Scoreboard bench for piezo_melody_seq: expected per-cycle outputs are queued from a
// note-table model as stimulus is driven, and popped against the DUT every cycle.
module tb_piezo_melody_seq;

  logic clk = 1'b0;
  logic rst_n, start, stop, loop_en, sel;
  always #5 clk = ~clk;

  logic       a_pz, a_pzn, a_busy, b_pz, b_pzn, b_busy;
  logic [1:0] a_idx, b_idx;
  logic [2:0] a_state, b_state;

  piezo_melody_seq #(
    .NUM_NOTES(3), .PER_W(15), .DUR_W(8), .TICK_DIV(4),
    .NOTE_PER({15'd4, 15'd6, 15'd8}), .NOTE_DUR({8'd1, 8'd3, 8'd2}), .PAUSE_DUR(8'd2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .piezo(a_pz), .piezo_n(a_pzn), .busy(a_busy), .note_idx(a_idx), .state(a_state)
  );

  piezo_melody_seq #(
    .NUM_NOTES(3), .PER_W(15), .DUR_W(8), .TICK_DIV(4),
    .NOTE_PER({15'd4, 15'd1, 15'd8}), .NOTE_DUR({8'd1, 8'd0, 8'd2}), .PAUSE_DUR(8'd2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .piezo(b_pz), .piezo_n(b_pzn), .busy(b_busy), .note_idx(b_idx), .state(b_state)
  );

  int per_a[3] = '{8, 6, 4};
  int dur_a[3] = '{2, 3, 1};
  int per_b[3] = '{8, 1, 4};
  int dur_b[3] = '{2, 0, 1};

  logic [7:0] sb_q[$];
  int total = 0;
  int bad = 0;
  string cur_tag = "reset";

  task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got st/busy/idx/pz/pzn=%b exp=%b @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic bz, input int idx,
                      input logic pz, input logic pzn);
    logic [1:0] i2;
    i2 = idx[1:0];
    sb_q.push_back({st, bz, i2, pz, pzn});
  endtask

  task automatic push_note(input int per, input int dur, input int idx, input int limit);
    int d, n;
    logic pz;
    d = (dur < 1) ? 1 : dur;
    n = d * 4;
    if (limit < n) n = limit;
    for (int c = 0; c < n; c++) begin
      pz = (per >= 2) && ((c % per) < (per / 2));
      push(3'b010, 1'b1, idx, pz, (per >= 2) && !pz);
    end
  endtask

  task automatic push_phrase(input bit use_b);
    for (int i = 0; i < 3; i++) begin
      if (use_b) push_note(per_b[i], dur_b[i], i, 1000);
      else       push_note(per_a[i], dur_a[i], i, 1000);
    end
  endtask

  task automatic push_pause(input int n);
    for (int c = 0; c < n; c++) push(3'b100, 1'b1, 2, 1'b0, 1'b0);
  endtask

  task automatic push_idle(input int n);
    for (int c = 0; c < n; c++) push(3'b001, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic step();
    logic [7:0] got, exp;
    @(posedge clk);
    @(negedge clk);
    got = sel ? {b_state, b_busy, b_idx, b_pz, b_pzn} : {a_state, a_busy, a_idx, a_pz, a_pzn};
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk_eq(cur_tag, got, exp);
    end
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_all();
    while (sb_q.size() > 0) step();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; sel = 1'b0;
    push_idle(1);
    step();
    rst_n = 1'b1;
    push_idle(1);
    step();

    cur_tag = "one_shot";
    push_phrase(1'b0); push_pause(8); push_idle(2);
    start_pulse();
    run_all();

    cur_tag = "loop";
    loop_en = 1'b1;
    push_phrase(1'b0); push_pause(8); push_phrase(1'b0); push_pause(8);
    start_pulse();
    run_all();
    push_phrase(1'b0);
    step();
    loop_en = 1'b0;
    push_pause(8); push_idle(2);
    run_all();

    cur_tag = "stop_note1";
    push_note(per_a[0], dur_a[0], 0, 1000);
    push_note(per_a[1], dur_a[1], 1, 5);
    start_pulse();
    run_all();
    stop = 1'b1;
    push_idle(1);
    step();
    stop = 1'b0;
    push_idle(2);
    run_all();

    cur_tag = "start_stop_idle";
    start = 1'b1; stop = 1'b1;
    push_idle(2);
    run_n(2);
    start = 1'b0; stop = 1'b0;

    cur_tag = "start_mid_play";
    push_phrase(1'b0); push_pause(8); push_idle(1);
    start_pulse();
    run_n(10);
    start = 1'b1;
    run_n(1);
    start = 1'b0;
    run_all();

    cur_tag = "reset_in_pause";
    push_phrase(1'b0); push_pause(3);
    start_pulse();
    run_all();
    rst_n = 1'b0;
    push_idle(1);
    step();
    rst_n = 1'b1;
    push_idle(1);
    step();
    push_phrase(1'b0); push_pause(8); push_idle(1);
    start_pulse();
    run_all();

    cur_tag = "rest_note";
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sel = 1'b1;
    push_idle(1);
    step();
    push_phrase(1'b1); push_pause(8); push_idle(2);
    start_pulse();
    run_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
